// File: rtl/flash_rom_loader_pkg.sv
// Shared definitions for the boot-time flash-to-RAM copy engine and other flash clients.
// Holds the loader state encoding, its counter limits and the flash reader request timing.
package flash_rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_REQ      = 3'd2,
    ST_XFER     = 3'd3,
    ST_WRITE    = 3'd4,
    ST_GAP      = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERR      = 3'd7
  } state_t;

  localparam int GAP_CYCLES = 2;
  localparam int MAX_RETRY  = 3;
  localparam int TIMER_W    = 4;
  localparam int RETRY_W    = 2;

  // Flash reader request timing, in clk cycles.
  localparam int FLASH_BUSY_LAT_MIN = 2;
  localparam int FLASH_BUSY_LAT_MAX = 3;
  localparam int FLASH_XFER_CYCLES  = 28;
  localparam int FLASH_CMD_CYCLES   = 8;

  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/flash_rom_loader_if.sv
// Request/response signals between a flash client (master) and the dual-IO SPI flash reader (slave).
interface flash_rom_loader_if;
  logic [23:0] flash_addr;
  logic        flash_cs;
  logic        flash_ready;
  logic        flash_busy;
  logic [7:0]  flash_dout;

  modport master (
    output flash_addr, flash_cs,
    input  flash_ready, flash_busy, flash_dout
  );

  modport slave (
    input  flash_addr, flash_cs,
    output flash_ready, flash_busy, flash_dout
  );
endinterface

// File: rtl/flash_rom_loader.sv
// Copies LENGTH bytes from flash starting at SRC_BASE into on-chip RAM after reset or on start,
// retrying unanswered requests and flagging done/error when finished.
module flash_rom_loader
  import flash_rom_loader_pkg::*;
#(
  parameter logic [23:0] SRC_BASE  = 24'h100000,
  parameter int          LENGTH    = 16384,
  parameter int          DST_AW    = 14,
  parameter bit          AUTOSTART = 1'b1,
  parameter int          TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  flash_rom_loader_if.master flash,
  output logic [DST_AW-1:0]  ram_addr,
  output logic [7:0]         ram_data,
  output logic               ram_we,
  output logic               loading,
  output logic               done,
  output logic               error
);

  localparam int                  CNT_W      = cnt_width(LENGTH);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(LENGTH - 1);
  localparam logic [TIMER_W-1:0]  TO_LOAD    = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]  GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [RETRY_W-1:0]  RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [RETRY_W-1:0]  retry_reg, retry_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [DST_AW-1:0]   ram_addr_reg, ram_addr_next;
  logic [7:0]          ram_data_reg, ram_data_next;
  logic                ram_we_reg, ram_we_next;
  logic                auto_pend_reg, auto_pend_next;
  logic                restart_pend_reg, restart_pend_next;
  logic                launch;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      retry_reg        <= '0;
      timer_reg        <= '0;
      ram_addr_reg     <= '0;
      ram_data_reg     <= '0;
      ram_we_reg       <= 1'b0;
      auto_pend_reg    <= AUTOSTART;
      restart_pend_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      retry_reg        <= retry_next;
      timer_reg        <= timer_next;
      ram_addr_reg     <= ram_addr_next;
      ram_data_reg     <= ram_data_next;
      ram_we_reg       <= ram_we_next;
      auto_pend_reg    <= auto_pend_next;
      restart_pend_reg <= restart_pend_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    retry_next        = retry_reg;
    timer_next        = timer_reg;
    ram_addr_next     = ram_addr_reg;
    ram_data_next     = ram_data_reg;
    ram_we_next       = 1'b0;
    auto_pend_next    = auto_pend_reg;
    restart_pend_next = restart_pend_reg;
    launch            = 1'b0;

    case (state_reg)
      ST_IDLE:     launch = start || auto_pend_reg;
      ST_WAIT_RDY: begin
        if (flash.flash_ready) begin
          timer_next = TO_LOAD;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flash.flash_busy) begin
          state_next = ST_XFER;
        end else if (timer_reg == '0) begin
          // Request went unanswered: back off through GAP so the next rising edge is clean.
          if (retry_reg == RETRY_LAST) begin
            state_next = ST_ERR;
          end else begin
            retry_next = retry_reg + RETRY_W'(1);
            timer_next = GAP_LOAD;
            state_next = ST_GAP;
          end
        end else begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end
      ST_XFER: begin
        if (!flash.flash_busy) begin
          ram_data_next = flash.flash_dout;
          ram_addr_next = DST_AW'(cnt_reg);
          ram_we_next   = 1'b1;
          state_next    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        retry_next = '0;
        if (cnt_reg == CNT_LAST) begin
          // A start landing on the final write is honoured once the image is complete.
          restart_pend_next = start;
          state_next        = ST_DONE;
        end else begin
          cnt_next   = cnt_reg + CNT_W'(1);
          timer_next = GAP_LOAD;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer_reg == '0) begin
          timer_next = TO_LOAD;
          state_next = ST_REQ;
        end else begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end
      ST_DONE:     launch = start || restart_pend_reg;
      ST_ERR:      launch = start;
      default:     state_next = ST_IDLE;
    endcase

    if (launch) begin
      cnt_next          = '0;
      retry_next        = '0;
      auto_pend_next    = 1'b0;
      restart_pend_next = 1'b0;
      state_next        = ST_WAIT_RDY;
    end
  end

  assign flash.flash_addr = SRC_BASE + 24'(cnt_reg);
  assign flash.flash_cs   = (state_reg == ST_REQ);

  assign ram_addr = ram_addr_reg;
  assign ram_data = ram_data_reg;
  assign ram_we   = ram_we_reg;
  assign loading  = state_reg inside {ST_WAIT_RDY, ST_REQ, ST_XFER, ST_WRITE, ST_GAP};
  assign done     = (state_reg == ST_DONE);
  assign error    = (state_reg == ST_ERR);

endmodule

// File: tb/tb_flash_rom_loader.sv
// Self-checking bench for flash_rom_loader: behavioural flash with random latency and
// selectable ignored requests, a write monitor, and an image-level expected-content model.
module tb_flash_rom_loader;

  localparam logic [23:0] SRC_BASE = 24'h000010;
  localparam int LENGTH  = 4;
  localparam int DST_AW  = 4;
  localparam int TIMEOUT = 15;
  localparam int XFER_CYCLES = 28;
  localparam int CMD_CYCLES  = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic [DST_AW-1:0] ram_addr;
  logic [7:0] ram_data;
  logic ram_we, loading, done, error;

  flash_rom_loader_if fif();

  flash_rom_loader #(
    .SRC_BASE(SRC_BASE), .LENGTH(LENGTH), .DST_AW(DST_AW), .AUTOSTART(1'b1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .flash(fif.master),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .loading(loading), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Flash contents and ignore control, set by the test sequence.
  logic [7:0]  salt = 8'h00;
  logic [23:0] ign_addr = 24'h0;
  int          ign_target = 0;

  // Behavioural flash reader: two-flop cs edge detect, random busy latency, fixed transfer.
  logic cs_d1, cs_d2, fm_first;
  int fm_phase, fm_lat, fm_left;
  int ign_done = 0;
  logic [23:0] fm_addr;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_d1 <= 1'b0; cs_d2 <= 1'b0; fm_first <= 1'b1;
      fm_phase <= 0; fm_lat <= 0; fm_left <= 0; fm_addr <= '0;
      fif.flash_busy <= 1'b0; fif.flash_dout <= 8'h00;
    end else begin
      cs_d1 <= fif.flash_cs;
      cs_d2 <= cs_d1;
      case (fm_phase)
        0: if (cs_d1 && !cs_d2) begin
          if (ign_done < ign_target && fif.flash_addr == ign_addr) begin
            ign_done <= ign_done + 1;
          end else begin
            fm_addr  <= fif.flash_addr;
            fm_lat   <= int'($urandom_range(1, 0));
            fm_phase <= 1;
          end
        end
        1: if (fm_lat == 0) begin
          fif.flash_busy <= 1'b1;
          fif.flash_dout <= 8'($urandom);
          fm_left  <= XFER_CYCLES + (fm_first ? CMD_CYCLES : 0);
          fm_first <= 1'b0;
          fm_phase <= 2;
        end else begin
          fm_lat <= fm_lat - 1;
        end
        default: if (fm_left <= 1) begin
          fif.flash_busy <= 1'b0;
          fif.flash_dout <= fm_addr[7:0] ^ 8'hA5 ^ salt;
          fm_phase <= 0;
        end else begin
          fm_left <= fm_left - 1;
        end
      endcase
    end
  end

  // Monitor: records writes and counts protocol violations, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_addr_q[$];
  int wr_data_q[$];
  logic cs_prev, busy_prev, we_prev, done_prev;
  int low_run = 2, high_run = 0, cs_rises = 0, cs_viol = 0;
  int busy_fall_cyc = 0, last_we_cyc = 0, we_viol = 0, done_rises = 0, done_viol = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      cs_prev <= 1'b0; busy_prev <= 1'b0; we_prev <= 1'b0; done_prev <= 1'b0;
      low_run <= 2; high_run <= 0;
    end else begin
      cs_prev <= fif.flash_cs; busy_prev <= fif.flash_busy;
      we_prev <= ram_we; done_prev <= done;
      if (fif.flash_cs) begin
        low_run  <= 0;
        high_run <= high_run + 1;
        if (!cs_prev) begin
          cs_rises <= cs_rises + 1;
          if (low_run < 2) cs_viol <= cs_viol + 1;
        end
      end else begin
        low_run  <= low_run + 1;
        high_run <= 0;
        if (cs_prev && !busy_prev && high_run != TIMEOUT) cs_viol <= cs_viol + 1;
      end
      if (busy_prev && !fif.flash_busy) busy_fall_cyc <= cyc;
      if (ram_we) begin
        wr_addr_q.push_back(int'(ram_addr));
        wr_data_q.push_back(int'(ram_data));
        last_we_cyc <= cyc;
        if (we_prev || cyc != busy_fall_cyc + 1) we_viol <= we_viol + 1;
      end
      if (done && !done_prev) begin
        done_rises <= done_rises + 1;
        if (cyc != last_we_cyc + 1) done_viol <= done_viol + 1;
      end
    end
  end

  // Reference model: image byte i is the flash byte at SRC_BASE+i, landing at RAM address i.
  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] s);
    logic [23:0] a;
    a = SRC_BASE + 24'(i);
    return a[7:0] ^ 8'hA5 ^ s;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rises(input int target, input int limit, output bit ok);
    for (int i = 0; i < limit && done_rises < target; i++) @(negedge clk);
    ok = (done_rises >= target);
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; fif.flash_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({fif.flash_cs, fif.flash_addr} !== {1'b0, SRC_BASE}) begin
      miscompares++;
      $display("FAIL reset_flash: cs/addr got %b/%06h expected 0/%06h", fif.flash_cs, fif.flash_addr, SRC_BASE);
    end
    vectors++;
    if ({ram_we, ram_addr, ram_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_ram: we/addr/data got %b/%0h/%02h expected 0/0/00", ram_we, ram_addr, ram_data);
    end
    vectors++;
    if ({loading, done, error} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_status: loading/done/error got %b%b%b expected 000", loading, done, error);
    end
  endtask

  task automatic test_autostart_ready_wait();
    int base, rises0, d0;
    bit ok;
    salt = 8'h00;
    base = wr_addr_q.size(); rises0 = cs_rises; d0 = done_rises;
    resetn = 1'b1;
    repeat (500) @(negedge clk);
    vectors++;
    if (cs_rises != rises0 || fif.flash_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_wait_cs: rises got %0d expected 0", cs_rises - rises0);
    end
    vectors++;
    if (loading !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_wait_loading: got %b expected 1", loading);
    end
    fif.flash_ready = 1'b1;
    wait_rises(d0 + 1, 3000, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL autostart_done_timeout: done rises got %0d expected %0d", done_rises - d0, 1);
    end
    vectors++;
    if (wr_addr_q.size() - base != LENGTH) begin
      miscompares++;
      $display("FAIL autostart_count: got %0d expected %0d", wr_addr_q.size() - base, LENGTH);
    end
    for (int i = 0; i < LENGTH && base + i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[base+i] != i || wr_data_q[base+i] != int'(exp_byte(i, salt))) begin
        miscompares++;
        $display("FAIL autostart_write[%0d]: got (%0h,%02h) expected (%0h,%02h)", i,
                 wr_addr_q[base+i], wr_data_q[base+i], i, exp_byte(i, salt));
      end
      $display("write %0d: addr %0h data %02h", i, wr_addr_q[base+i], wr_data_q[base+i]);
    end
    vectors++;
    if ({done, loading, error} !== 3'b100) begin
      miscompares++;
      $display("FAIL autostart_status: done/loading/error got %b%b%b expected 100", done, loading, error);
    end
  endtask

  task automatic test_retry();
    int base, rises0, d0;
    bit ok;
    salt = 8'($urandom);
    ign_addr = SRC_BASE + 24'd1; ign_target = ign_done + 2;
    base = wr_addr_q.size(); rises0 = cs_rises; d0 = done_rises;
    pulse_start();
    wait_rises(d0 + 1, 3000, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL retry_done_timeout: done rises got %0d expected 1", done_rises - d0);
    end
    vectors++;
    if (cs_rises - rises0 != LENGTH + 2) begin
      miscompares++;
      $display("FAIL retry_requests: got %0d expected %0d", cs_rises - rises0, LENGTH + 2);
    end
    for (int i = 0; i < LENGTH && base + i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[base+i] != i || wr_data_q[base+i] != int'(exp_byte(i, salt))) begin
        miscompares++;
        $display("FAIL retry_write[%0d]: got (%0h,%02h) expected (%0h,%02h)", i,
                 wr_addr_q[base+i], wr_data_q[base+i], i, exp_byte(i, salt));
      end
    end
    vectors++;
    if (error !== 1'b0 || wr_addr_q.size() - base != LENGTH) begin
      miscompares++;
      $display("FAIL retry_status: error %b writes %0d expected error 0 writes %0d", error, wr_addr_q.size() - base, LENGTH);
    end
    $display("retry load: %0d requests, error %b", cs_rises - rises0, error);
  endtask

  task automatic test_error();
    int base;
    salt = 8'($urandom);
    ign_addr = SRC_BASE + 24'd1; ign_target = ign_done + 3;
    base = wr_addr_q.size();
    pulse_start();
    for (int i = 0; i < 3000 && error !== 1'b1; i++) @(negedge clk);
    vectors++;
    if ({error, fif.flash_cs, loading, done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL error_status: error/cs/loading/done got %b%b%b%b expected 1000", error, fif.flash_cs, loading, done);
    end
    repeat (100) @(negedge clk);
    vectors++;
    if (wr_addr_q.size() - base != 1) begin
      miscompares++;
      $display("FAIL error_writes: got %0d expected 1", wr_addr_q.size() - base);
    end else if (wr_data_q[base] != int'(exp_byte(0, salt))) begin
      miscompares++;
      $display("FAIL error_byte0: got %02h expected %02h", wr_data_q[base], exp_byte(0, salt));
    end
    $display("error load: error %b after %0d writes", error, wr_addr_q.size() - base);
  endtask

  task automatic test_reset_mid_xfer();
    int base, d0;
    bit ok;
    salt = 8'($urandom);
    base = wr_addr_q.size();
    pulse_start();
    for (int i = 0; i < 3000 && !(fif.flash_addr == SRC_BASE + 24'd2 && fif.flash_busy === 1'b1); i++)
      @(negedge clk);
    repeat ($urandom_range(10, 1)) @(negedge clk);
    resetn = 1'b0;
    #1;
    vectors++;
    if ({fif.flash_cs, fif.flash_addr, ram_we, ram_addr, ram_data, loading, done, error} !==
        {1'b0, SRC_BASE, 1'b0, {DST_AW{1'b0}}, 8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL midreset_outputs: cs %b addr %06h we %b raddr %0h rdata %02h l/d/e %b%b%b expected reset values",
               fif.flash_cs, fif.flash_addr, ram_we, ram_addr, ram_data, loading, done, error);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_addr_q.size() - base != 2) begin
      miscompares++;
      $display("FAIL midreset_partial: writes got %0d expected 2", wr_addr_q.size() - base);
    end
    base = wr_addr_q.size(); d0 = done_rises;
    resetn = 1'b1;
    wait_rises(d0 + 1, 3000, ok);
    vectors++;
    if (!ok || wr_addr_q.size() - base != LENGTH) begin
      miscompares++;
      $display("FAIL midreset_reload: writes got %0d expected %0d", wr_addr_q.size() - base, LENGTH);
    end
    for (int i = 0; i < LENGTH && base + i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[base+i] != i || wr_data_q[base+i] != int'(exp_byte(i, salt))) begin
        miscompares++;
        $display("FAIL midreset_write[%0d]: got (%0h,%02h) expected (%0h,%02h)", i,
                 wr_addr_q[base+i], wr_data_q[base+i], i, exp_byte(i, salt));
      end
    end
    $display("reload after reset: %0d writes", wr_addr_q.size() - base);
  endtask

  task automatic test_back_to_back();
    int base, d0;
    bit ok;
    salt = 8'($urandom);
    base = wr_addr_q.size(); d0 = done_rises;
    pulse_start();
    vectors++;
    if ({done, loading} !== 2'b01) begin
      miscompares++;
      $display("FAIL restart_clears_done: done/loading got %b%b expected 01", done, loading);
    end
    for (int i = 0; i < 3000 && wr_addr_q.size() < base + 2; i++) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 3000 && !(ram_we === 1'b1 && ram_addr == DST_AW'(LENGTH - 1)); i++)
      @(negedge clk);
    pulse_start();
    wait_rises(d0 + 2, 6000, ok);
    vectors++;
    if (!ok || wr_addr_q.size() - base != 2 * LENGTH) begin
      miscompares++;
      $display("FAIL b2b_count: writes got %0d expected %0d", wr_addr_q.size() - base, 2 * LENGTH);
    end
    for (int i = 0; i < 2 * LENGTH && base + i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[base+i] != i % LENGTH || wr_data_q[base+i] != int'(exp_byte(i % LENGTH, salt))) begin
        miscompares++;
        $display("FAIL b2b_write[%0d]: got (%0h,%02h) expected (%0h,%02h)", i,
                 wr_addr_q[base+i], wr_data_q[base+i], i % LENGTH, exp_byte(i % LENGTH, salt));
      end
    end
    vectors++;
    if ({done, loading, error} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_status: done/loading/error got %b%b%b expected 100", done, loading, error);
    end
    $display("back-to-back: %0d writes, %0d done pulses", wr_addr_q.size() - base, done_rises - d0);
  endtask

  task automatic test_protocol();
    vectors++;
    if (cs_viol != 0) begin
      miscompares++;
      $display("FAIL cs_edges: violations got %0d expected 0", cs_viol);
    end
    vectors++;
    if (we_viol != 0) begin
      miscompares++;
      $display("FAIL we_timing: violations got %0d expected 0", we_viol);
    end
    vectors++;
    if (done_viol != 0) begin
      miscompares++;
      $display("FAIL done_timing: violations got %0d expected 0", done_viol);
    end
  endtask

  initial begin
    fif.flash_ready = 1'b0;
    test_reset();
    test_autostart_ready_wait();
    test_retry();
    test_error();
    test_reset_mid_xfer();
    test_back_to_back();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
